// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction-fetch stage feeding the decode stage. Owns the fetch PC, issues
// single-outstanding requests to instruction memory over a req/ack handshake,
// buffers returned words in a 2-entry {pc, instr} FIFO and presents at most one
// {instr, pc} pair per cycle to decode. Honours decode's stall, and its flush
// with redirect for taken branches/jumps.
//
// Optional feature macro: IF_ALIGN_CHECK_EN
//   When defined, a flush to a non-word-aligned target pulses o_fetch_fault
//   for one cycle and halts fetching until rst. When undefined, the port is
//   absent and the low two bits of the redirect target are ignored.
//
// Parameters:
//   RESET_PC      fetch address after reset
//   NOP_INSTR     value driven on o_instr when no valid instruction is shown
//
// Ports:
//   clk            clock, all state on the rising edge
//   rst            synchronous active-high reset
//   i_stall        decode stall: hold the output register
//   i_flush        decode flush (taken branch/jump), priority over stall
//   i_branch_pc    redirect target, valid with i_flush
//   o_imem_req     memory request valid
//   o_imem_addr    memory request address (word aligned)
//   i_imem_ack     request complete, i_imem_data valid this cycle
//   i_imem_data    fetched instruction word
//   o_instr        instruction to decode
//   o_pc           PC of o_instr
//   o_ce           o_instr/o_pc valid
//   o_fetch_fault  misaligned redirect pulse (IF_ALIGN_CHECK_EN only)
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [31:0] i_branch_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_data,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_ce
`ifdef IF_ALIGN_CHECK_EN
  ,
  output logic        o_fetch_fault
`endif
);

  // REQ : request at pc_fetch outstanding
  // HOLD: FIFO full, no request
  // DROP: stale request outstanding, its data is thrown away
  // HALT: fetching stopped after a misaligned redirect
  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;
`ifdef IF_ALIGN_CHECK_EN
  localparam logic [1:0] ST_HALT = 2'd3;
`endif

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_fetch_q, pc_fetch_d;
  logic [31:0] drop_addr_q, drop_addr_d;

  logic [63:0] fifo_q [0:1];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [63:0] head;

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        ce_q, ce_d;

  logic        push;
  logic        pop;
  logic [31:0] flush_target;

`ifdef IF_ALIGN_CHECK_EN
  logic        misaligned;
  logic        fault_q, fault_d;
  logic        halt_pend_q, halt_pend_d;
  assign misaligned = |i_branch_pc[1:0];
`endif

  // The redirect target is always forced onto a word boundary.
  assign flush_target = i_branch_pc & 32'hFFFF_FFFC;

  // Data is only kept when it answers a live (non-stale) request and no
  // flush is discarding it in the same cycle.
  assign push = (state_q == ST_REQ) && i_imem_ack && !i_flush;
  assign pop  = !i_stall && !i_flush && (count_q != 2'd0);
  assign head = fifo_q[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default at the top so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop;
      count_d  = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    ce_d    = ce_q;
    if (i_flush) begin
      ce_d    = 1'b0;
      instr_d = NOP_INSTR;
    end else if (!i_stall) begin
      if (count_q != 2'd0) begin
        instr_d = head[31:0];
        pc_d    = head[63:32];
        ce_d    = 1'b1;
      end else begin
        ce_d    = 1'b0;
        instr_d = NOP_INSTR;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch FSM and fetch PC
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    pc_fetch_d  = pc_fetch_q;
    drop_addr_d = drop_addr_q;
`ifdef IF_ALIGN_CHECK_EN
    fault_d     = 1'b0;
    halt_pend_d = halt_pend_q;
`endif
    if (i_flush) begin
      pc_fetch_d = flush_target;
      case (state_q)
        // A request cannot be cancelled: if it is still pending, keep driving
        // its address until the ack arrives and then discard the data.
        ST_REQ: begin
          if (i_imem_ack) begin
            state_d = ST_REQ;
          end else begin
            state_d     = ST_DROP;
            drop_addr_d = pc_fetch_q;
          end
        end
        ST_DROP: state_d = i_imem_ack ? ST_REQ : ST_DROP;
        ST_HOLD: state_d = ST_REQ;
        default: state_d = state_q;
      endcase
`ifdef IF_ALIGN_CHECK_EN
      if (misaligned) begin
        fault_d     = 1'b1;
        halt_pend_d = 1'b1;
      end
`endif
    end else begin
      case (state_q)
        ST_REQ: begin
          if (i_imem_ack) begin
            pc_fetch_d = pc_fetch_q + 32'd4;
            // Only launch the next request if a slot will be free for it.
            if (count_d == 2'd2) state_d = ST_HOLD;
          end
        end
        ST_HOLD: if (count_d != 2'd2) state_d = ST_REQ;
        ST_DROP: if (i_imem_ack) state_d = ST_REQ;
        default: state_d = state_q;
      endcase
    end
`ifdef IF_ALIGN_CHECK_EN
    // A pending halt waits for any stale request to complete first.
    if (halt_pend_d && (state_d != ST_DROP)) state_d = ST_HALT;
`endif
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_REQ;
      pc_fetch_q  <= RESET_PC;
      drop_addr_q <= RESET_PC;
      count_q     <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      instr_q     <= NOP_INSTR;
      pc_q        <= RESET_PC;
      ce_q        <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
      fault_q     <= 1'b0;
      halt_pend_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_fetch_q  <= pc_fetch_d;
      drop_addr_q <= drop_addr_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      ce_q        <= ce_d;
`ifdef IF_ALIGN_CHECK_EN
      fault_q     <= fault_d;
      halt_pend_q <= halt_pend_d;
`endif
    end
  end

  // NOTE: the FIFO storage is deliberately not reset; the count and pointers
  // decide validity, so the data array can map onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {pc_fetch_q, i_imem_data};
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The request is a function of state only; rst masks it so nothing is
  // requested while reset holds the FSM in REQ.
  assign o_imem_req  = !rst && ((state_q == ST_REQ) || (state_q == ST_DROP));
  assign o_imem_addr = (state_q == ST_DROP) ? drop_addr_q : pc_fetch_q;
  assign o_instr     = instr_q;
  assign o_pc        = pc_q;
  assign o_ce        = ce_q;
`ifdef IF_ALIGN_CHECK_EN
  assign o_fetch_fault = fault_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed self-checking bench for instr_fetch. A small instruction-memory
// model answers each request after a programmable latency (1 = zero wait)
// with data = address ^ 32'hA5A5_0000.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] XK  = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        i_stall;
  logic        i_flush;
  logic [31:0] i_branch_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_data;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        o_ce;
`ifdef IF_ALIGN_CHECK_EN
  logic        o_fetch_fault;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Memory model: ack in the lat-th cycle of a request.
  logic [3:0] lat;
  logic [3:0] wait_cnt;

  assign i_imem_ack  = o_imem_req && (wait_cnt == lat - 4'd1);
  assign i_imem_data = o_imem_addr ^ XK;

  always @(posedge clk) begin
    if (rst)              wait_cnt <= 4'd0;
    else if (o_imem_req)  wait_cnt <= i_imem_ack ? 4'd0 : wait_cnt + 4'd1;
  end

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .i_stall     (i_stall),
    .i_flush     (i_flush),
    .i_branch_pc (i_branch_pc),
    .o_imem_req  (o_imem_req),
    .o_imem_addr (o_imem_addr),
    .i_imem_ack  (i_imem_ack),
    .i_imem_data (i_imem_data),
    .o_instr     (o_instr),
    .o_pc        (o_pc),
    .o_ce        (o_ce)
`ifdef IF_ALIGN_CHECK_EN
    ,
    .o_fetch_fault (o_fetch_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled and inputs driven 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},   o_imem_req,  32'd0);
    check({tag, "_addr"},  o_imem_addr, 32'h0);
    check({tag, "_instr"}, o_instr,     NOP);
    check({tag, "_pc"},    o_pc,        32'h0);
    check({tag, "_ce"},    o_ce,        32'd0);
`ifdef IF_ALIGN_CHECK_EN
    check({tag, "_fault"}, o_fetch_fault, 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b1; i_stall = 1'b0; i_flush = 1'b0; i_branch_pc = 32'h0; lat = 4'd1;
    repeat (3) tick();
    check_reset_values("rst");

    // ---- Reset release, zero-wait streaming ----
    rst = 1'b0;
    #1;                                   // C0
    check("c0_req",  o_imem_req,  32'd1);
    check("c0_addr", o_imem_addr, 32'h0);
    tick();                               // C1
    check("c1_addr", o_imem_addr, 32'h4);
    check("c1_ce",   o_ce,        32'd0);
    for (int k = 2; k <= 5; k++) begin
      tick();
      check("strm_addr",  o_imem_addr, 32'(4 * k));
      check("strm_ce",    o_ce,        32'd1);
      check("strm_pc",    o_pc,        32'(4 * (k - 2)));
      check("strm_instr", o_instr,     32'(4 * (k - 2)) ^ XK);
    end

    // ---- Stall for cycles C5..C9 (output shows pc 12, FIFO holds 16) ----
    i_stall = 1'b1;
    for (int k = 6; k <= 10; k++) begin
      tick();
      check("stall_pc",  o_pc,       32'd12);
      check("stall_ce",  o_ce,       32'd1);
      check("stall_req", o_imem_req, 32'd0);
    end
    i_stall = 1'b0;
    tick();                               // C11
    check("rel_pc0",  o_pc,        32'd16);
    check("rel_ins0", o_instr,     32'd16 ^ XK);
    check("rel_req",  o_imem_req,  32'd1);
    check("rel_addr", o_imem_addr, 32'd24);
    tick();                               // C12
    check("rel_pc1",  o_pc,        32'd20);
    check("rel_ce1",  o_ce,        32'd1);
    tick();                               // C13
    check("rel_pc2",  o_pc,        32'd24);

    // ---- Flush coinciding with an ack (zero wait), target 0x40 ----
    i_flush = 1'b1; i_branch_pc = 32'h40;
    tick();                               // F+1
    i_flush = 1'b0;
    check("fl_req",   o_imem_req,  32'd1);
    check("fl_addr",  o_imem_addr, 32'h40);
    check("fl_ce1",   o_ce,        32'd0);
    check("fl_nop",   o_instr,     NOP);
    tick();                               // F+2
    check("fl_ce2",   o_ce,        32'd0);
    check("fl_addr2", o_imem_addr, 32'h44);
    tick();                               // F+3
    check("fl_ce3",   o_ce,        32'd1);
    check("fl_pc3",   o_pc,        32'h40);
    check("fl_ins3",  o_instr,     32'hA5A5_0040);

    // ---- PC wrap: redirect to 0xFFFF_FFFC ----
    i_flush = 1'b1; i_branch_pc = 32'hFFFF_FFFC;
    tick();
    i_flush = 1'b0;
    check("wr_addr0", o_imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wr_addr1", o_imem_addr, 32'h0000_0000);
    tick();
    check("wr_pc0",   o_pc,        32'hFFFF_FFFC);
    check("wr_ins0",  o_instr,     32'h5A5A_FFFC);
    tick();
    check("wr_pc1",   o_pc,        32'h0000_0000);
    check("wr_ins1",  o_instr,     32'hA5A5_0000);

    // ---- Reset while a request is pending ----
    lat = 4'd3;
    rst = 1'b1;
    tick();
    check_reset_values("mid_rst");
    tick();

    // ---- 3-cycle memory, flush into a pending request ----
    rst = 1'b0;
    #1;                                   // C0: request 0 pending
    check("dr_c0_addr", o_imem_addr, 32'h0);
    i_flush = 1'b1; i_branch_pc = 32'h20;
    tick();                               // C1
    i_flush = 1'b0;
    check("dr_c1_req",  o_imem_req,  32'd1);
    check("dr_c1_addr", o_imem_addr, 32'h0);
    tick();                               // C2: stale ack
    check("dr_c2_addr", o_imem_addr, 32'h0);
    tick();                               // C3: request 0x20
    check("dr_c3_addr", o_imem_addr, 32'h20);
    tick();                               // C4
    i_flush = 1'b1; i_branch_pc = 32'h100;
    check("dr_c4_addr", o_imem_addr, 32'h20);
    tick();                               // C5: 0x20 still driven, acked
    i_flush = 1'b0;
    check("dr_c5_req",  o_imem_req,  32'd1);
    check("dr_c5_addr", o_imem_addr, 32'h20);
    check("dr_c5_ce",   o_ce,        32'd0);
    tick();                               // C6
    check("dr_c6_addr", o_imem_addr, 32'h100);
    check("dr_c6_ce",   o_ce,        32'd0);
    for (int k = 7; k <= 9; k++) begin
      tick();
      check("dr_gap_ce", o_ce, 32'd0);
    end
    tick();                               // C10
    check("dr_ce",  o_ce,    32'd1);
    check("dr_pc",  o_pc,    32'h100);
    check("dr_ins", o_instr, 32'hA5A5_0100);

    // ---- Misaligned redirect to 0x102 ----
    lat = 4'd1;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
    i_flush = 1'b1; i_branch_pc = 32'h102;
    tick();                               // F+1
    i_flush = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
    check("al_fault1", o_fetch_fault, 32'd1);
    check("al_req1",   o_imem_req,    32'd0);
    tick();
    check("al_fault2", o_fetch_fault, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("al_halt_req", o_imem_req, 32'd0);
    end
    rst = 1'b1;
    tick();
    check("al_rst_fault", o_fetch_fault, 32'd0);
    rst = 1'b0;
    #1;
    check("al_rst_req", o_imem_req, 32'd1);
`else
    check("al_req",   o_imem_req,  32'd1);
    check("al_addr",  o_imem_addr, 32'h100);
    tick();
    check("al_addr2", o_imem_addr, 32'h104);
    tick();
    check("al_ce",    o_ce,        32'd1);
    check("al_pc",    o_pc,        32'h100);
    check("al_ins",   o_instr,     32'hA5A5_0100);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
